// File: rtl/decode_queue.sv
// Decode-on-enqueue instruction queue: 1-cycle min latency empty->out_valid, no bypass.
// Backpressure: in_ready drops when full or flushing; head held stable until out_ready.
module decode_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [15:0]                out_ctrl,
    output logic [3:0]                 out_exc,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [15:0] C_RW  = 16'h8000, C_RD  = 16'h4000, C_AS  = 16'h2000, C_BR  = 16'h1000;
    localparam logic [15:0] C_MW  = 16'h0800, C_MTR = 16'h0400, C_JP  = 16'h0200, C_MRD = 16'h0100;
    localparam logic [15:0] C_HW  = 16'h0080, C_HR  = 16'h0040, C_PR  = 16'h0020, C_R31 = 16'h0010;
    localparam logic [15:0] C_PJR = 16'h0008, C_SE  = 16'h0004, C_CW  = 16'h0002, C_CR  = 16'h0001;

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt;
    logic [15:0] dec_ctrl;
    logic        dec_ri, dec_brk, dec_sys, dec_eret;

    assign op = in_instr[31:26];
    assign rs = in_instr[25:21];
    assign rt = in_instr[20:16];
    assign fn = in_instr[5:0];

    always_comb begin
        dec_ctrl = '0;
        dec_ri   = 1'b0;
        dec_brk  = 1'b0;
        dec_sys  = 1'b0;
        dec_eret = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B:               dec_ctrl = C_RW | C_RD;
                    6'h08:                                    dec_ctrl = C_PJR;
                    6'h09:                                    dec_ctrl = C_RW | C_RD | C_PJR;
                    6'h0C:                                    dec_sys  = 1'b1;
                    6'h0D:                                    dec_brk  = 1'b1;
                    6'h10, 6'h12:                             dec_ctrl = C_RW | C_RD | C_HR;
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: dec_ctrl = C_HW;
                    default:                                  dec_ri   = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: dec_ctrl = C_BR;
                    5'h10, 5'h11: dec_ctrl = C_RW | C_RD | C_BR | C_PR | C_R31;
                    default:      dec_ri   = 1'b1;
                endcase
            end
            6'h02:                      dec_ctrl = C_JP;
            6'h03:                      dec_ctrl = C_RW | C_RD | C_JP | C_PR | C_R31;
            6'h04, 6'h05, 6'h06, 6'h07: dec_ctrl = C_BR;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: dec_ctrl = C_RW | C_AS;
            6'h10: begin
                if (in_instr == 32'h4200_0018) dec_eret = 1'b1;
                else if (rs == 5'h00)          dec_ctrl = C_RW | C_CR;
                else if (rs == 5'h04)          dec_ctrl = C_CW;
                else                           dec_ri   = 1'b1;
            end
            // Custom RELU lives in the SPECIAL2 opcode space
            6'h1C: begin
                if (RELU_EN && fn == 6'h00) dec_ctrl = C_RW | C_RD;
                else                        dec_ri   = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: dec_ctrl = C_RW | C_AS | C_MTR | C_MRD;
            6'h28, 6'h29, 6'h2B:               dec_ctrl = C_AS | C_MW;
            default:                           dec_ri   = 1'b1;
        endcase
        if (!dec_ri) dec_ctrl[2] = (op[5:2] != 4'b0011);
    end

    logic [31:0]      mem_instr_q [DEPTH];
    logic [PC_W-1:0]  mem_pc_q    [DEPTH];
    logic [15:0]      mem_ctrl_q  [DEPTH];
    logic [3:0]       mem_exc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq, deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count_q != CNT_W'(DEPTH)) & ~flush;
    assign out_valid = (count_q != '0);
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready & ~flush;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (enq && !deq)      count_d = count_q + 1'b1;
            else if (!enq && deq) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: head outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr_q[wr_ptr_q] <= in_instr;
            mem_pc_q[wr_ptr_q]    <= in_pc;
            mem_ctrl_q[wr_ptr_q]  <= dec_ctrl;
            mem_exc_q[wr_ptr_q]   <= {dec_ri, dec_brk, dec_sys, dec_eret};
        end
    end

    assign out_instr = out_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? mem_pc_q[rd_ptr_q]    : '0;
    assign out_ctrl  = out_valid ? mem_ctrl_q[rd_ptr_q]  : '0;
    assign out_exc   = out_valid ? mem_exc_q[rd_ptr_q]   : '0;
endmodule

// File: tb/tb_decode_queue.sv
// Randomized and directed bench for decode_queue against a queue-based reference model.
module tb_decode_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, nr_in_ready, nr_out_valid;
    logic [31:0] out_instr, out_pc, nr_out_instr, nr_out_pc;
    logic [15:0] out_ctrl, nr_ctrl;
    logic [3:0]  out_exc, nr_exc;
    logic [2:0]  count, nr_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .PC_W(32), .RELU_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_ctrl(out_ctrl), .out_exc(out_exc),
        .count(count));

    decode_queue #(.DEPTH(DEPTH), .PC_W(32), .RELU_EN(1'b0)) u_norelu (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nr_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(nr_out_valid), .out_ready(out_ready),
        .out_instr(nr_out_instr), .out_pc(nr_out_pc), .out_ctrl(nr_ctrl), .out_exc(nr_exc),
        .count(nr_count));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decode: classify the instruction, then OR the named control bits together
    function automatic logic [19:0] model_decode(input logic [31:0] w, input bit relu);
        int op, fn, rs, rt;
        logic [15:0] c;
        logic [3:0]  x;
        op = int'(w[31:26]); fn = int'(w[5:0]); rs = int'(w[25:21]); rt = int'(w[20:16]);
        c = 16'h0; x = 4'h0;
        if (op == 0) begin
            if (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43}) c = 16'h8000 | 16'h4000;
            else if (fn == 8)  c = 16'h0008;
            else if (fn == 9)  c = 16'h8000 | 16'h4000 | 16'h0008;
            else if (fn == 12) x = 4'b0010;
            else if (fn == 13) x = 4'b0100;
            else if (fn inside {16, 18}) c = 16'h8000 | 16'h4000 | 16'h0040;
            else if (fn inside {17, 19, [24:27]}) c = 16'h0080;
            else x = 4'b1000;
        end else if (op == 1) begin
            if (rt inside {0, 1}) c = 16'h1000;
            else if (rt inside {16, 17}) c = 16'h8000 | 16'h4000 | 16'h1000 | 16'h0020 | 16'h0010;
            else x = 4'b1000;
        end else if (op == 2) c = 16'h0200;
        else if (op == 3) c = 16'h8000 | 16'h4000 | 16'h0200 | 16'h0020 | 16'h0010;
        else if (op inside {[4:7]}) c = 16'h1000;
        else if (op inside {[8:15]}) c = 16'h8000 | 16'h2000;
        else if (op == 16) begin
            if (w == 32'h4200_0018) x = 4'b0001;
            else if (rs == 0) c = 16'h8000 | 16'h0001;
            else if (rs == 4) c = 16'h0002;
            else x = 4'b1000;
        end else if (op == 28) begin
            if (relu && fn == 0) c = 16'h8000 | 16'h4000;
            else x = 4'b1000;
        end else if (op inside {32, 33, 35, 36, 37}) c = 16'h8000 | 16'h2000 | 16'h0400 | 16'h0100;
        else if (op inside {40, 41, 43}) c = 16'h2000 | 16'h0800;
        else x = 4'b1000;
        if (x != 4'b1000 && !(op inside {[12:15]})) c = c | 16'h0004;
        return {x, c};
    endfunction

    task automatic check_outputs(input bit fl);
        logic [19:0] d, dn;
        chk("count", 32'(count), 32'(mq.size()));
        chk("nr_count", 32'(nr_count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH && !fl));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            d  = model_decode(mq[0].instr, 1'b1);
            dn = model_decode(mq[0].instr, 1'b0);
            chk("head_pc", out_pc, mq[0].pc);
            chk("head_instr", out_instr, mq[0].instr);
            chk("head_ctrl", 32'(out_ctrl), 32'(d[15:0]));
            chk("head_exc", 32'(out_exc), 32'(d[19:16]));
            chk("nr_ctrl", 32'(nr_ctrl), 32'(dn[15:0]));
            chk("nr_exc", 32'(nr_exc), 32'(dn[19:16]));
        end else begin
            chk("idle_pc", out_pc, 32'h0);
            chk("idle_instr", out_instr, 32'h0);
            chk("idle_ctrl", 32'(out_ctrl), 32'h0);
            chk("idle_exc", 32'(out_exc), 32'h0);
        end
    endtask

    // One clock cycle: drive at negedge, check, then update the model on the edge
    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
        bit acc, pop;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        check_outputs(fl);
        acc = v && (mq.size() < DEPTH) && !fl;
        pop = ordy && (mq.size() != 0) && !fl;
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back('{pc: pc, instr: ins});
        end
        @(negedge clk);
    endtask

    logic [31:0] tmpl [28] = '{
        32'h00430821, 32'h8C410004, 32'hAC410004, 32'h0C000010, 32'h08000010, 32'h10220003,
        32'h04110002, 32'h04100002, 32'h04010002, 32'h3C011234, 32'h34210001, 32'h24210001,
        32'h03E00008, 32'h0040F809, 32'h0000000C, 32'h0000000D, 32'h00430018, 32'h00001010,
        32'h00400011, 32'h40016000, 32'h40816000, 32'h42000018, 32'h70430800, 32'hFC000000,
        32'h00000001, 32'h04050000, 32'h42100000, 32'h1C400005};

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        if ($urandom_range(0, 4) == 0) return $urandom();
        w = tmpl[$urandom_range(0, 27)];
        if ($urandom_range(0, 1) == 1) w = w ^ ($urandom() & 32'h0000FFC0);
        return w;
    endfunction

    initial begin
        logic [31:0] t2_ins  [4] = '{32'h8C410004, 32'h0C000010, 32'hFC000000, 32'h42000018};
        logic [15:0] t2_ctrl [4] = '{16'hA504, 16'hC234, 16'h0000, 16'h0004};
        logic [3:0]  t2_exc  [4] = '{4'b0000, 4'b0000, 4'b1000, 4'b0001};
        logic [31:0] pc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'h0);
        rst = 1'b0;

        // Single addu: visible the cycle after enqueue
        cyc(1, 32'h00430821, 32'hBFC00000, 0, 0);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_ctrl", 32'(out_ctrl), 32'hC004);
        chk("t1_exc", 32'(out_exc), 32'h0);
        chk("t1_pc", out_pc, 32'hBFC00000);
        cyc(0, 0, 0, 1, 0);

        for (int i = 0; i < 4; i++) cyc(1, t2_ins[i], 32'h1000 + 32'(4 * i), 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_ctrl", 32'(out_ctrl), 32'(t2_ctrl[i]));
            chk("t2_exc", 32'(out_exc), 32'(t2_exc[i]));
            cyc(0, 0, 0, 1, 0);
        end

        // Full queue holds off a fifth instruction until a slot frees
        for (int i = 0; i < 4; i++) cyc(1, tmpl[i], 32'h2000 + 32'(4 * i), 0, 0);
        chk("t3_full_count", 32'(count), 32'h4);
        chk("t3_full_rdy", 32'(in_ready), 32'h0);
        repeat (3) cyc(1, tmpl[9], 32'h2010, 0, 0);
        cyc(1, tmpl[9], 32'h2010, 1, 0);
        cyc(1, tmpl[9], 32'h2010, 0, 0);
        chk("t3_refill_count", 32'(count), 32'h4);
        repeat (6) cyc(0, 0, 0, 1, 0);

        // Flush while full with both handshakes offered
        for (int i = 0; i < 4; i++) cyc(1, tmpl[i + 4], 32'h3000 + 32'(4 * i), 0, 0);
        cyc(1, tmpl[10], 32'h3010, 1, 1);
        chk("t4_count", 32'(count), 32'h0);
        chk("t4_valid", 32'(out_valid), 32'h0);
        repeat (3) cyc(0, 0, 0, 1, 0);

        // Streaming across pointer wrap
        for (int i = 0; i < 20; i++) begin
            cyc(1, tmpl[i % 28], 32'h4000 + 32'(4 * i), 1, 0);
            chk("t5_count", 32'(count), 32'h1);
        end
        cyc(0, 0, 0, 1, 0);

        cyc(1, 32'h70430800, 32'h5000, 0, 0);
        chk("t6_relu_ctrl", 32'(out_ctrl), 32'hC004);
        chk("t6_relu_exc", 32'(out_exc), 32'h0);
        chk("t6_norelu_ctrl", 32'(nr_ctrl), 32'h0);
        chk("t6_norelu_exc", 32'(nr_exc), 32'h8);
        cyc(0, 0, 0, 1, 0);

        // Asynchronous reset in mid-operation
        for (int i = 0; i < 3; i++) cyc(1, tmpl[i + 12], 32'h6000 + 32'(4 * i), 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'h0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;

        pc = 32'h8000;
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0, rand_instr(), pc,
                $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
            pc = pc + 32'h4;
        end
        repeat (6) cyc(0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
